// File: rtl/loader_pkg.sv
// Shared definitions for the byte-stream program loader: FSM states,
// default frame marker and state classification helpers.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_HI,
    ST_LO,
    ST_WRITE,
    ST_CHK,
    ST_RELEASE,
    ST_ERROR
  } state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // States in which a byte may be taken from the source.
  function automatic logic accepts_bytes(input state_e s);
    return !(s == ST_WRITE || s == ST_RELEASE);
  endfunction

  // States in which the loader is waiting for the next byte of a frame.
  function automatic logic inside_frame(input state_e s);
    return (s == ST_LEN || s == ST_HI || s == ST_LO || s == ST_CHK);
  endfunction

endpackage

// File: rtl/idle_timer.sv
// Counts idle cycles while enabled; expired flags the cycle whose edge
// would bring the idle count to TIMEOUT.
module idle_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/prog_loader.sv
// Frame parser that writes 16-bit words into instruction memory with the CPU
// held, then releases it with a restart pulse once the checksum matches.
module prog_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              imem_we,
  output logic              cpu_hold,
  output logic              cpu_restart,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [7:0]        n_q, n_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        xor_q, xor_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic              restart_q, restart_d;
  logic              err_q, err_d;

  logic accept;
  logic timer_clear;
  logic timer_en;
  logic expired;

  assign accept      = rx_valid && ready_q;
  assign timer_en    = inside_frame(state_q);
  assign timer_clear = accept || !timer_en;

  idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    xor_d   = xor_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;

    unique case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (accept && rx_data == SYNC_BYTE) begin
          state_d = ST_LEN;
          hold_d  = 1'b1;
        end
      end
      ST_LEN: begin
        if (accept) begin
          if (rx_data == 8'd0) begin
            state_d = ST_ERROR;
          end else begin
            n_d     = rx_data;
            cnt_d   = 8'd0;
            xor_d   = 8'd0;
            addr_d  = '0;
            state_d = ST_HI;
          end
        end else if (expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_HI: begin
        if (accept) begin
          hi_d    = rx_data;
          xor_d   = xor_q ^ rx_data;
          state_d = ST_LO;
        end else if (expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_LO: begin
        if (accept) begin
          wdata_d = {hi_q, rx_data};
          xor_d   = xor_q ^ rx_data;
          state_d = ST_WRITE;
        end else if (expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = cnt_q + 8'd1;
        state_d = (cnt_q + 8'd1 == n_q) ? ST_CHK : ST_HI;
      end
      ST_CHK: begin
        if (accept) begin
          state_d = (rx_data == xor_q) ? ST_RELEASE : ST_ERROR;
        end else if (expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    if (state_d == ST_RELEASE) begin
      hold_d = 1'b0;
    end
    we_d      = (state_d == ST_WRITE);
    restart_d = (state_d == ST_RELEASE);
    err_d     = (state_d == ST_ERROR);
    ready_d   = accepts_bytes(state_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      n_q       <= 8'd0;
      cnt_q     <= 8'd0;
      xor_q     <= 8'd0;
      hi_q      <= 8'd0;
      addr_q    <= '0;
      wdata_q   <= 16'd0;
      hold_q    <= 1'b0;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      restart_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      xor_q     <= xor_d;
      hi_q      <= hi_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      hold_q    <= hold_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      restart_q <= restart_d;
      err_q     <= err_d;
    end
  end

  assign rx_ready    = ready_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign imem_we     = we_q;
  assign cpu_hold    = hold_q;
  assign cpu_restart = restart_q;
  assign done        = restart_q;
  assign err         = err_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader that writes 16-bit instruction words into instruction memory while holding the CPU in halt. It sits between a byte source (UART receiver or bench driver) and the instruction-memory write port. On a verified frame it releases the CPU with a one-cycle restart pulse, so the fetch-decode-execute sequencer starts at address 0 on a freshly loaded program.

## Interface
- `ADDR_W`, 8: instruction-memory address width; must be ≥ 8.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT`, 1024: maximum idle clock cycles between bytes inside a frame.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: incoming byte.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: loader can accept a byte. A byte transfers on a rising edge with `rx_valid & rx_ready`.
- `imem_addr` out ADDR_W: write address (word index).
- `imem_wdata` out 16: instruction word, `{hi, lo}`.
- `imem_we` out 1: single-cycle write strobe.
- `cpu_hold` out 1: holds the CPU halted while high.
- `cpu_restart` out 1: one-cycle pulse that resets the CPU cycle counter and PC.
- `done` out 1: one-cycle pulse on a successful load.
- `err` out 1: sticky error flag.

## Operation
- Frame format: `SYNC_BYTE`, `N` (word count, 1..255), N×(hi byte, lo byte), then `CHK`.
- `CHK` is the XOR of all 2N data bytes.
- States and transitions:
  - IDLE: discard bytes until `SYNC_BYTE` is received, then go to LEN.
  - LEN: on `N == 0`, go to ERROR. Otherwise latch N, clear the address, word count and XOR, then go to HI.
  - HI: latch the hi byte, then go to LO.
  - LO: latch the lo byte, then go to WRITE.
  - WRITE: assert `imem_we`. Increment the address and word count. If count == N, go to CHK; otherwise go to HI.
  - CHK: on a match go to RELEASE; on a mismatch go to ERROR.
  - RELEASE: pulse `cpu_restart` and `done`, then go to IDLE.
  - ERROR: `err = 1`. Discard bytes. `SYNC_BYTE` clears `err` and goes to LEN.
- Running XOR accumulates every data byte as it is accepted in HI and LO.
- `cpu_hold` sets on acceptance of `SYNC_BYTE` from IDLE or ERROR. It clears only in RELEASE and stays high in ERROR.
- Timeout: an idle counter resets on every accepted byte and counts in LEN, HI, LO and CHK. When it reaches `TIMEOUT`, the state goes to ERROR.
- `imem_addr` is ADDR_W wide; the frame limits it to 0..254, so it never wraps.

## Timing
- Reset values: state IDLE, `rx_ready`=0 during reset then 1, `imem_addr`=0, `imem_wdata`=0, `imem_we`=0, `cpu_hold`=0, `cpu_restart`=0, `done`=0, `err`=0.
- `rx_ready` = 1 in IDLE, LEN, HI, LO, CHK and ERROR; 0 in WRITE and RELEASE.
- Write latency: `imem_we` is high exactly in the cycle after the lo byte is accepted. `imem_addr` and `imem_wdata` are stable in that cycle.
- Best-case throughput: one word per 3 cycles, with back-to-back `rx_valid`.
- `cpu_restart` and `done` rise in the same cycle that `cpu_hold` falls. Each is high for one cycle.
- Simultaneous timeout expiry and byte acceptance: the byte wins and the counter resets.
- `reset_n` low mid-frame: immediate return to reset values. `cpu_hold` drops. Partially written memory is not restored.
- `rx_valid` with `rx_ready`=0: no transfer; the source must hold the byte.

## Structure
- Shared package `loader_pkg`: state enum (IDLE, LEN, HI, LO, WRITE, CHK, RELEASE, ERROR) and the default `SYNC_BYTE`.
- One natural sub-module: `idle_timer`, parameterised by `TIMEOUT`, with `clear`/`enable`/`expired`.
- Everything else stays in `prog_loader`.

## Test plan
- **Good frame:** A5, 02, 08 01, 10 02, CHK=0x1B.
  - Writes 0x0801@0 and 0x1002@1.
  - `done` and `cpu_restart` pulse once; `cpu_hold` goes 1→0; `err`=0.
- **Bad checksum:** A5, 01, 12 34, CHK=00.
  - Writes 0x1234@0, then `err`=1 and `cpu_hold` stays 1; no `done`.
  - A following good frame clears `err` and completes.
- **Zero length:** A5, 00 → ERROR, `err`=1, no `imem_we`.
- **Noise before sync:** 00, FF, 3C, then a good frame → leading bytes ignored, `cpu_hold` stays 0 until A5.
- **Stall:** A5, 01, 12, then `TIMEOUT` idle cycles → `err`=1. A gap of `TIMEOUT`−1 cycles does not error.
- **Reset mid-frame:** assert `reset_n`=0 during HI of word 3 of 5 → all outputs return to reset values. A new frame loads normally.
